dircc_send_handler: RTL and testbench

//  Consumer end of the RTS path: takes the per-port rts_ready flags from the device's RTS handler.

---
 rtl/dircc_application_pkg.sv | 22 ++
 rtl/dircc_types_pkg.sv | 25 ++
 rtl/dircc_rr_arbiter.sv | 29 ++
 rtl/dircc_send_handler.sv | 123 ++++++++++++
 tb/tb_dircc_send_handler.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dircc_application_pkg.sv
// Counter application state, shared between the RTS and send handlers.
package dircc_application_pkg;

    typedef struct packed {
        logic [15:0] rts;
        logic [15:0] count;
    } dev_state_t;

    typedef struct packed {
        logic [31:0] dircc_state;
        dev_state_t  user_state;
    } device_state_t;

    // One packet sent: consume an rts credit, bump the counter.
    function automatic dev_state_t counter_step(input dev_state_t s);
        dev_state_t r;
        r.rts   = (s.rts == 16'd0) ? 16'd0 : s.rts - 16'd1;
        r.count = s.count + 16'd1;
        return r;
    endfunction

endpackage

// File: rtl/dircc_types_pkg.sv
// Shared DIRCC types: device-state flags, network packet, send FSM states.
package dircc_types_pkg;

    localparam int DIRCC_ADDR_W = 32;

    localparam logic [31:0] DIRCC_STATE_RUNNING = 32'h0000_0001;

    localparam logic [31:0] OUTPUT_FLAG_NONE  = 32'h0000_0000;
    localparam logic [31:0] OUTPUT_FLAG_PORT0 = 32'h0000_0001;

    typedef struct packed {
        logic [DIRCC_ADDR_W-1:0] src;
        logic [4:0]              port;
        logic [31:0]             payload;
    } dircc_packet_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WB,
        S_HOLD
    } send_state_e;

endpackage

// File: rtl/dircc_rr_arbiter.sv
// Round-robin pick: lowest requesting port at or above the pointer, wrapping.
module dircc_rr_arbiter #(
    parameter int NUM_PORTS = 32
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [4:0]           pointer_i,
    output logic [4:0]           grant_idx_o,
    output logic                 grant_any_o
);

    always_comb begin
        logic [5:0] idx;
        idx         = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        // Scan downwards so the nearest port past the pointer wins last.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = {1'b0, pointer_i} + 6'(i);
            if (idx >= 6'(NUM_PORTS)) begin
                idx = idx - 6'(NUM_PORTS);
            end
            if (req_i[idx[4:0]]) begin
                grant_any_o = 1'b1;
                grant_idx_o = idx[4:0];
            end
        end
    end

endmodule

// File: rtl/dircc_send_handler.sv
// Drains rts_ready flags: arbitrate a port, send one packet, write back state.
module dircc_send_handler
    import dircc_types_pkg::*;
    import dircc_application_pkg::*;
#(
    parameter int ADDRESS_MEM_WIDTH = 32,
    parameter     NODE_TYPE         = "default",
    parameter int NUM_PORTS         = 32,
    parameter int HOLDOFF_CYCLES    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDRESS_MEM_WIDTH-1:0] address,
    input  logic [31:0]                  rts_ready,
    input  device_state_t                read_state,
    output dircc_packet_t                tx_packet,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output device_state_t                write_state,
    output logic                         write_en,
    output logic                         busy
);

    localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

    send_state_e   state_q;
    logic [4:0]    grant_q;
    logic [4:0]    ptr_q;
    logic [HOLD_W-1:0] hold_q;
    dircc_packet_t tx_packet_q;
    logic          tx_valid_q;
    device_state_t write_state_q;
    logic          write_en_q;

    logic [4:0]    grant_idx;
    logic          grant_any;
    logic          running;
    device_state_t wb_d;

    dircc_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .req_i       (rts_ready[NUM_PORTS-1:0]),
        .pointer_i   (ptr_q),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    assign running = (read_state.dircc_state & DIRCC_STATE_RUNNING) != '0;

    // Only the counter application knows how to advance its user state.
    if (NODE_TYPE == "default") begin : g_counter
        always_comb begin
            wb_d            = read_state;
            wb_d.user_state = counter_step(read_state.user_state);
        end
    end else begin : g_passthru
        assign wb_d = read_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            ptr_q         <= '0;
            hold_q        <= '0;
            tx_packet_q   <= '0;
            tx_valid_q    <= 1'b0;
            write_state_q <= '0;
            write_en_q    <= 1'b0;
        end else begin
            write_en_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        grant_q <= grant_idx;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (running && read_state.user_state.rts != 16'd0) begin
                        tx_packet_q.src     <= DIRCC_ADDR_W'(address);
                        tx_packet_q.port    <= grant_q;
                        tx_packet_q.payload <= {16'b0, read_state.user_state.count};
                        tx_valid_q          <= 1'b1;
                        state_q             <= S_SEND;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        tx_valid_q    <= 1'b0;
                        write_state_q <= wb_d;
                        write_en_q    <= 1'b1;
                        state_q       <= S_WB;
                    end
                end
                S_WB: begin
                    ptr_q   <= (grant_q == 5'(NUM_PORTS - 1)) ? 5'd0 : grant_q + 5'd1;
                    hold_q  <= '0;
                    state_q <= (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLD;
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_packet   = tx_packet_q;
    assign tx_valid    = tx_valid_q;
    assign write_state = write_state_q;
    assign write_en    = write_en_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_dircc_send_handler.sv
// Directed bench for dircc_send_handler: send path, round-robin, stalls, reset.
module tb_dircc_send_handler;
    import dircc_types_pkg::*;
    import dircc_application_pkg::*;

    localparam logic [31:0] ADDR = 32'hC0DE_0042;
    localparam logic [31:0] OTHER_BITS = 32'hA500_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   rts_ready;
    device_state_t read_state;
    dircc_packet_t tx_packet;
    logic          tx_valid;
    logic          tx_ready;
    device_state_t write_state;
    logic          write_en;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int wcnt     = 0;
    int hcnt     = 0;
    int w0, h0;

    dircc_send_handler #(
        .ADDRESS_MEM_WIDTH (32),
        .NODE_TYPE         ("default"),
        .NUM_PORTS         (32),
        .HOLDOFF_CYCLES    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (ADDR),
        .rts_ready   (rts_ready),
        .read_state  (read_state),
        .tx_packet   (tx_packet),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .write_state (write_state),
        .write_en    (write_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_en) wcnt++;
        if (tx_valid && tx_ready) hcnt++;
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic device_state_t mk(input logic run, input logic [15:0] rts,
                                         input logic [15:0] cnt);
        device_state_t s;
        s.dircc_state      = OTHER_BITS | (run ? DIRCC_STATE_RUNNING : 32'h0);
        s.user_state.rts   = rts;
        s.user_state.count = cnt;
        return s;
    endfunction

    function automatic dircc_packet_t mkpkt(input logic [4:0] port,
                                            input logic [15:0] cnt);
        dircc_packet_t p;
        p.src     = ADDR;
        p.port    = port;
        p.payload = {16'h0, cnt};
        return p;
    endfunction

    // FSM idle, flag and state already presented; runs one full packet.
    task automatic send_one(input logic [4:0] port, input logic [15:0] cnt,
                            input device_state_t ws);
        tx_ready = 1'b1;
        step();
        chk("busy_load", 128'(busy), 128'(1'b1));
        chk("txv_load", 128'(tx_valid), 128'(1'b0));
        step();
        chk("txv_send", 128'(tx_valid), 128'(1'b1));
        chk("pkt_send", 128'(tx_packet), 128'(mkpkt(port, cnt)));
        step();
        chk("wen_wb", 128'(write_en), 128'(1'b1));
        chk("ws_wb", 128'(write_state), 128'(ws));
        chk("txv_wb", 128'(tx_valid), 128'(1'b0));
        step();
        chk("wen_hold", 128'(write_en), 128'(1'b0));
        chk("busy_hold", 128'(busy), 128'(1'b1));
        step();
        chk("busy_hold2", 128'(busy), 128'(1'b1));
        step();
        chk("busy_idle", 128'(busy), 128'(1'b0));
    endtask

    initial begin
        reset      = 1'b1;
        rts_ready  = '0;
        read_state = '0;
        tx_ready   = 1'b0;
        step();
        step();
        chk("rst_txv", 128'(tx_valid), 128'(1'b0));
        chk("rst_wen", 128'(write_en), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_pkt", 128'(tx_packet), 128'(0));
        chk("rst_ws", 128'(write_state), 128'(0));
        reset = 1'b0;

        // Single packet on port 0.
        read_state = mk(1'b1, 16'd3, 16'd5);
        rts_ready  = 32'h1;
        send_one(5'd0, 16'd5, mk(1'b1, 16'd2, 16'd6));
        rts_ready = '0;
        chk("t1_wcnt", 128'(wcnt), 128'(1));
        chk("t1_hcnt", 128'(hcnt), 128'(1));

        // Round-robin from pointer 0, back-to-back, then wrap past 31.
        reset = 1'b1;
        step();
        reset = 1'b0;
        read_state = mk(1'b1, 16'd10, 16'd0);
        rts_ready  = 32'h0000_0005;
        send_one(5'd0, 16'd0, mk(1'b1, 16'd9, 16'd1));
        send_one(5'd2, 16'd0, mk(1'b1, 16'd9, 16'd1));
        send_one(5'd0, 16'd0, mk(1'b1, 16'd9, 16'd1));
        rts_ready = 32'h8000_0000;
        send_one(5'd31, 16'd0, mk(1'b1, 16'd9, 16'd1));
        rts_ready = 32'h8000_0001;
        send_one(5'd0, 16'd0, mk(1'b1, 16'd9, 16'd1));
        rts_ready = '0;

        // Back-pressure for 7 cycles; RUNNING drops mid-stall.
        read_state = mk(1'b1, 16'd4, 16'd7);
        rts_ready  = 32'h10;
        tx_ready   = 1'b0;
        step();
        step();
        rts_ready = '0;
        chk("t3_txv", 128'(tx_valid), 128'(1'b1));
        chk("t3_pkt", 128'(tx_packet), 128'(mkpkt(5'd4, 16'd7)));
        for (int i = 0; i < 7; i++) begin
            if (i == 3) read_state = mk(1'b0, 16'd4, 16'd7);
            step();
            chk("t3_txv_hold", 128'(tx_valid), 128'(1'b1));
            chk("t3_pkt_hold", 128'(tx_packet), 128'(mkpkt(5'd4, 16'd7)));
            chk("t3_wen_hold", 128'(write_en), 128'(1'b0));
        end
        tx_ready = 1'b1;
        step();
        chk("t3_wen", 128'(write_en), 128'(1'b1));
        chk("t3_ws", 128'(write_state), 128'(mk(1'b0, 16'd3, 16'd8)));
        step();
        step();
        step();
        chk("t3_busy_idle", 128'(busy), 128'(1'b0));

        // Not running, then no credits: nothing is sent or written.
        w0 = wcnt;
        h0 = hcnt;
        read_state = mk(1'b0, 16'd3, 16'd5);
        rts_ready  = 32'h1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4a_txv", 128'(tx_valid), 128'(1'b0));
            chk("t4a_wen", 128'(write_en), 128'(1'b0));
        end
        read_state = mk(1'b1, 16'd0, 16'd5);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4b_txv", 128'(tx_valid), 128'(1'b0));
            chk("t4b_wen", 128'(write_en), 128'(1'b0));
        end
        rts_ready = '0;
        step();
        step();
        chk("t4_wcnt", 128'(wcnt - w0), 128'(0));
        chk("t4_hcnt", 128'(hcnt - h0), 128'(0));

        // Counter wrap and last credit; stale flag held through HOLD.
        w0 = wcnt;
        h0 = hcnt;
        read_state = mk(1'b1, 16'd1, 16'hFFFF);
        rts_ready  = 32'h1;
        send_one(5'd0, 16'hFFFF, mk(1'b1, 16'd0, 16'd0));
        read_state = mk(1'b1, 16'd0, 16'd0);
        rts_ready  = '0;
        step();
        step();
        step();
        chk("t5_hcnt", 128'(hcnt - h0), 128'(1));
        chk("t5_wcnt", 128'(wcnt - w0), 128'(1));

        // Reset while stalled in SEND abandons the packet.
        w0 = wcnt;
        read_state = mk(1'b1, 16'd3, 16'd5);
        rts_ready  = 32'h1;
        tx_ready   = 1'b0;
        step();
        step();
        chk("t6_txv_send", 128'(tx_valid), 128'(1'b1));
        reset = 1'b1;
        step();
        chk("t6_txv_rst", 128'(tx_valid), 128'(1'b0));
        chk("t6_busy_rst", 128'(busy), 128'(1'b0));
        chk("t6_wen_rst", 128'(write_en), 128'(1'b0));
        reset     = 1'b0;
        rts_ready = '0;
        step();
        chk("t6_wcnt", 128'(wcnt - w0), 128'(0));
        rts_ready = 32'h1;
        send_one(5'd0, 16'd5, mk(1'b1, 16'd2, 16'd6));
        rts_ready = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
